// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared FSM state encoding and opcode constants
package fetch_sequencer_pkg;
   typedef enum logic [2:0] {BOOT, FETCH, WAIT_ACK, EXEC, HALT} state_t;
   localparam logic [5:0] OPC_JUMP = 6'b010111;
   localparam logic [5:0] OPC_HLT  = 6'b011000;
   localparam logic [5:0] OPC_RST  = 6'b011001;
endpackage

// File: rtl/fetch_sequencer_pc_next_calc.sv
// pc_next_calc: prioritised next-PC mux applied when execute feedback arrives
module pc_next_calc #(
   parameter int ADDR_W = 10,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              fb_reset,
   input  logic              fb_hlt,
   input  logic              fb_jump,
   input  logic              fb_branch,
   input  logic              fb_zero,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic [ADDR_W-1:0] branch_off,
   output logic [ADDR_W-1:0] pc_next
);
   logic [ADDR_W-1:0] pc_inc;
   always_comb begin
      pc_inc  = pc + ADDR_W'(1);
      pc_next = fb_reset               ? RESET_PC :
                fb_hlt                 ? pc :
                fb_jump                ? jump_target :
                (fb_branch && fb_zero) ? pc_inc + branch_off :
                                         pc_inc;
   end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-issue fetch FSM with req/ack imem handshake and feedback-driven PC
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int INSTR_W = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [5:0]         opcode,
   output logic               instr_valid,
   input  logic               fb_valid,
   input  logic               fb_jump,
   input  logic               fb_branch,
   input  logic               fb_zero,
   input  logic               fb_hlt,
   input  logic               fb_reset,
   input  logic [ADDR_W-1:0]  jump_target,
   input  logic [ADDR_W-1:0]  branch_off,
   input  logic               resume,
   output logic [ADDR_W-1:0]  pc,
   output logic               halted
);
   state_t            state;
   logic [ADDR_W-1:0] pc_next;

   pc_next_calc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc_next (
      .pc(pc), .fb_reset(fb_reset), .fb_hlt(fb_hlt), .fb_jump(fb_jump),
      .fb_branch(fb_branch), .fb_zero(fb_zero), .jump_target(jump_target),
      .branch_off(branch_off), .pc_next(pc_next)
   );

   assign imem_addr = pc;
   assign opcode    = instr[INSTR_W-1 -: 6];

   // imem_req is raised on entry to FETCH so it is already visible during the FETCH cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
         halted      <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               state    <= FETCH;
               imem_req <= 1'b1;
            end
            FETCH: state <= WAIT_ACK;
            WAIT_ACK: if (imem_ack) begin
               instr       <= imem_rdata;
               imem_req    <= 1'b0;
               instr_valid <= 1'b1;
               state       <= EXEC;
            end
            EXEC: if (fb_valid) begin
               instr_valid <= 1'b0;
               pc          <= pc_next;
               if (fb_hlt && !fb_reset) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else begin
                  state    <= FETCH;
                  imem_req <= 1'b1;
               end
            end
            HALT: if (resume) begin
               pc       <= pc + ADDR_W'(1);
               halted   <= 1'b0;
               imem_req <= 1'b1;
               state    <= FETCH;
            end
            default: state <= BOOT;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table, directed and randomized checks against a PC reference model
module tb_fetch_sequencer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic        fb_valid, fb_jump, fb_branch, fb_zero, fb_hlt, fb_reset;
   logic [9:0]  jump_target, branch_off;
   logic        resume;
   logic [9:0]  pc;
   logic        halted;

   int tests = 0;
   int fails = 0;
   logic [9:0] mpc;

   fetch_sequencer dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
      .instr_valid(instr_valid), .fb_valid(fb_valid), .fb_jump(fb_jump),
      .fb_branch(fb_branch), .fb_zero(fb_zero), .fb_hlt(fb_hlt), .fb_reset(fb_reset),
      .jump_target(jump_target), .branch_off(branch_off), .resume(resume),
      .pc(pc), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] start;
      logic r, h, j, b, z;
      logic [9:0] jt, off, exp_pc;
   } vec_t;
   vec_t v[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] ref_pc(input logic [9:0] p, input logic r, h, j, b, z,
                                         input logic [9:0] jt, off);
      int n;
      if (r) return 10'd0;
      if (h) return p;
      if (j) return jt;
      n = (b && z) ? int'(p) + 1 + int'($signed(off)) : int'(p) + 1;
      return 10'(((n % 1024) + 1024) % 1024);
   endfunction

   task automatic fetch(input logic [31:0] word, input int dly);
      int k = 0;
      while (!imem_req && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!imem_req) begin
         chk("req_timeout", 32'd0, 32'd1);
         return;
      end
      chk("fetch_addr", imem_addr, mpc);
      repeat (dly) @(negedge clk);
      chk("req_held", {imem_req, imem_addr}, {1'b1, mpc});
      imem_ack = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      chk("valid_noreq", {instr_valid, imem_req}, 2'b10);
      chk("instr", instr, word);
      chk("opcode", opcode, word[31:26]);
   endtask

   task automatic exec(input logic r, h, j, b, z, input logic [9:0] jt, off);
      fb_valid = 1'b1;
      {fb_reset, fb_hlt, fb_jump, fb_branch, fb_zero} = {r, h, j, b, z};
      jump_target = jt;
      branch_off = off;
      @(negedge clk);
      {fb_valid, fb_reset, fb_hlt, fb_jump, fb_branch, fb_zero} = '0;
      jump_target = $urandom;
      branch_off = $urandom;
      mpc = ref_pc(mpc, r, h, j, b, z, jt, off);
      chk("exec_pc", pc, mpc);
      chk("exec_state", {instr_valid, halted}, {1'b0, h && !r});
   endtask

   task automatic do_resume();
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      mpc = mpc + 10'd1;
   endtask

   initial begin
      v[0] = '{10'h008, 0, 0, 0, 1, 1, 10'h000, 10'h3FD, 10'h006};
      v[1] = '{10'h008, 0, 0, 0, 1, 0, 10'h000, 10'h3FD, 10'h009};
      v[2] = '{10'h3FF, 0, 0, 0, 0, 0, 10'h000, 10'h000, 10'h000};
      v[3] = '{10'h005, 0, 0, 1, 0, 0, 10'h155, 10'h000, 10'h155};
      v[4] = '{10'h005, 1, 0, 1, 0, 0, 10'h155, 10'h000, 10'h000};
      v[5] = '{10'h3FE, 0, 0, 0, 1, 1, 10'h000, 10'h005, 10'h004};
      v[6] = '{10'h100, 0, 0, 1, 1, 1, 10'h020, 10'h007, 10'h020};
      v[7] = '{10'h010, 0, 0, 0, 1, 1, 10'h000, 10'h000, 10'h011};
      rst_n = 1'b0;
      {imem_ack, fb_valid, fb_jump, fb_branch, fb_zero, fb_hlt, fb_reset, resume} = '0;
      imem_rdata = '0;
      jump_target = '0;
      branch_off = '0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {imem_req, instr_valid, halted, pc}, 13'd0);
      chk("reset_instr", {instr, opcode}, 38'd0);
      rst_n = 1'b1;
      mpc = 10'd0;
      fetch(32'h2C00_0005, 2);
      chk("t1_opcode", opcode, 6'b001011);
      exec(0, 0, 0, 0, 0, 10'd0, 10'd0);
      chk("t1_pc", pc, 10'd1);
      foreach (v[i]) begin
         fetch($urandom, 1);
         exec(0, 0, 1, 0, 0, v[i].start, 10'd0);
         fetch($urandom, 1);
         exec(v[i].r, v[i].h, v[i].j, v[i].b, v[i].z, v[i].jt, v[i].off);
         chk($sformatf("vec%0d_pc", i), pc, v[i].exp_pc);
      end
      fetch($urandom, 1);
      chk("t2_addr", imem_addr, 10'h011);
      exec(0, 1, 0, 0, 0, 10'd0, 10'd0);
      chk("halt_flag", halted, 1'b1);
      for (int i = 0; i < 20; i++) begin
         fb_valid = i[0];
         {fb_reset, fb_jump, fb_branch, fb_zero, imem_ack} = 5'($urandom);
         jump_target = $urandom;
         @(negedge clk);
         chk("halt_hold", {imem_req, halted, pc}, {2'b01, mpc});
      end
      {fb_valid, fb_reset, fb_jump, fb_branch, fb_zero, imem_ack} = '0;
      do_resume();
      fetch($urandom, 1);
      chk("resume_addr", pc, 10'h012);
      exec(0, 0, 0, 0, 0, 10'd0, 10'd0);
      @(negedge clk);
      chk("wait_ack_req", imem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("async_drop", {imem_req, instr_valid, pc}, 12'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mpc = 10'd0;
      fetch($urandom, 3);
      exec(0, 0, 0, 0, 0, 10'd0, 10'd0);
      for (int it = 0; it < 200; it++) begin
         logic [31:0] w;
         logic r, h, j, b, z;
         w = $urandom;
         fetch(w, $urandom_range(1, 3));
         repeat ($urandom_range(0, 3)) begin
            imem_ack = ($urandom % 3 == 0);
            imem_rdata = $urandom;
            @(negedge clk);
            imem_ack = 1'b0;
            chk("exec_hold", {instr_valid, imem_req, instr}, {2'b10, w});
         end
         r = ($urandom % 10 == 0);
         h = ($urandom % 8 == 0);
         j = ($urandom % 4 == 0);
         b = 1'($urandom);
         z = 1'($urandom);
         exec(r, h, j, b, z, 10'($urandom), 10'($urandom));
         if (h && !r) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            do_resume();
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
